// File: rtl/os_result_drain_if.sv
// os_result_drain_if.sv - row-per-beat result stream between the drain and the write-back path
//
// Signals:
//   out_data   COLS*WIDTH_MUL  one row of results, column c at [c*WIDTH_MUL +: WIDTH_MUL]
//   out_row    RW              row index of out_data
//   out_valid  1               beat valid
//   out_ready  1               sink accepts the beat
//   out_last   1               beat carries the final row of the tile
// Modports: master (drain side), slave (write-back side).
interface os_result_drain_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WIDTH_MUL = 32
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COLS*WIDTH_MUL-1:0] out_data;
    logic [RW-1:0]             out_row;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (
        output out_data,
        output out_row,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/os_result_drain.sv
// os_result_drain.sv - snapshots an output-stationary PE array and streams it out one row per beat
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   acc_flat  all PE accumulators, element (r,c) at [(r*COLS+c)*WIDTH_MUL +: WIDTH_MUL]
//   done      one-cycle pulse: tile accumulation complete
//   err_clr   clears the sticky overrun flag
//   pe_clear  one-cycle pulse zeroing the PE accumulators after a capture
//   busy      snapshot held, drain not finished
//   overrun   sticky: done arrived while a drain was in progress
//   out_s     row stream (os_result_drain_if.master)
// Build option: define OS_DRAIN_RELU_EN to replace negative elements by 0 at capture.
module os_result_drain #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WIDTH_MUL = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ROWS*COLS*WIDTH_MUL-1:0] acc_flat,
    input  logic                          done,
    input  logic                          err_clr,
    output logic                          pe_clear,
    output logic                          busy,
    output logic                          overrun,
    os_result_drain_if.master             out_s
);
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_BITS = COLS * WIDTH_MUL;
    localparam int ALL_BITS = ROWS * ROW_BITS;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state;
    logic [ALL_BITS-1:0] snap;
    logic [ALL_BITS-1:0] cap;
    logic [RW-1:0]       next_row;
    logic                hs;
    logic                at_last;
    logic                accept;

    // Capture value: raw accumulators, or clamped at zero when the ReLU build is selected.
    always_comb begin
        cap = acc_flat;
`ifdef OS_DRAIN_RELU_EN
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (acc_flat[i*WIDTH_MUL + WIDTH_MUL - 1]) begin
                cap[i*WIDTH_MUL +: WIDTH_MUL] = '0;
            end
        end
`endif
    end

    // out_row doubles as the drain pointer.
    assign hs       = out_s.out_valid & out_s.out_ready;
    assign at_last  = (out_s.out_row == LAST_ROW);
    assign next_row = out_s.out_row + RW'(1);
    // A new tile is taken when idle, or exactly when the last row of the current tile leaves.
    assign accept   = done & ((state == IDLE) | (hs & at_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            snap            <= '0;
            pe_clear        <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            out_s.out_data  <= '0;
            out_s.out_row   <= '0;
            out_s.out_valid <= 1'b0;
            out_s.out_last  <= 1'b0;
        end else begin
            pe_clear <= 1'b0;

            // A set event outranks a simultaneous clear.
            if (done && !accept) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (accept) begin
                state           <= DRAIN;
                snap            <= cap;
                pe_clear        <= 1'b1;
                busy            <= 1'b1;
                out_s.out_data  <= cap[0 +: ROW_BITS];
                out_s.out_row   <= '0;
                out_s.out_valid <= 1'b1;
                out_s.out_last  <= (ROWS == 1);
            end else if (state == DRAIN && hs) begin
                if (at_last) begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    out_s.out_valid <= 1'b0;
                    out_s.out_last  <= 1'b0;
                end else begin
                    out_s.out_data <= snap[int'(next_row)*ROW_BITS +: ROW_BITS];
                    out_s.out_row  <= next_row;
                    out_s.out_last <= (next_row == LAST_ROW);
                end
            end
        end
    end
endmodule

// File: tb/tb_os_result_drain.sv
// tb_os_result_drain.sv - scoreboard bench for os_result_drain
module tb_os_result_drain;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 32;
    localparam int RW   = 2;
    localparam int CW   = COLS * W;
    localparam int AW   = ROWS * CW;

    typedef struct {
        logic [CW-1:0] data;
        logic [RW-1:0] row;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] acc_flat = '0;
    logic          done = 1'b0;
    logic          err_clr = 1'b0;
    logic          pe_clear;
    logic          busy;
    logic          overrun;

    os_result_drain_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH_MUL(W)) bus ();

    os_result_drain #(.ROWS(ROWS), .COLS(COLS), .WIDTH_MUL(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_flat (acc_flat),
        .done     (done),
        .err_clr  (err_clr),
        .pe_clear (pe_clear),
        .busy     (busy),
        .overrun  (overrun),
        .out_s    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: beats still owed to the sink, sticky overrun, expected beats.
    int    owed = 0;
    logic  exp_ov = 1'b0;
    logic  exp_pe = 1'b0;
    beat_t exp_q[$];

    function automatic logic [W-1:0] elem(input logic [AW-1:0] a, input int r, input int c);
        logic [W-1:0] v;
        v = a[(r*COLS + c)*W +: W];
`ifdef OS_DRAIN_RELU_EN
        if ($signed(v) < 0) v = '0;
`endif
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owed   = 0;
            exp_ov = 1'b0;
            exp_pe = 1'b0;
            exp_q.delete();
        end else begin
            bit took, tk;
            took = (owed > 0) && bus.out_ready;
            tk   = done && (owed == 0 || (took && owed == 1));
            if (done && !tk) exp_ov = 1'b1;
            else if (err_clr) exp_ov = 1'b0;
            exp_pe = tk;
            if (tk) begin
                for (int r = 0; r < ROWS; r++) begin
                    beat_t b;
                    for (int c = 0; c < COLS; c++) b.data[c*W +: W] = elem(acc_flat, r, c);
                    b.row  = RW'(r);
                    b.last = (r == ROWS - 1);
                    exp_q.push_back(b);
                end
                owed = ROWS;
            end else if (took) begin
                owed = owed - 1;
            end
        end
    end

    // Monitor: sample between edges, pop one expected beat per handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", CW'(bus.out_valid), CW'(owed > 0));
            chk("busy", CW'(busy), CW'(owed > 0));
            chk("pe_clear", CW'(pe_clear), CW'(exp_pe));
            chk("overrun", CW'(overrun), CW'(exp_ov));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", CW'(1), CW'(0));
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("out_data", bus.out_data, b.data);
                    chk("out_row", CW'(bus.out_row), CW'(b.row));
                    chk("out_last", CW'(bus.out_last), CW'(b.last));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic d, input logic r, input logic e);
        done          = d;
        bus.out_ready = r;
        err_clr       = e;
        step();
    endtask

    task automatic rand_acc();
        for (int i = 0; i < ROWS * COLS; i++) acc_flat[i*W +: W] = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, CW'(bus.out_valid), '0);
        chk({tag, "_data"}, bus.out_data, '0);
        chk({tag, "_row"}, CW'(bus.out_row), '0);
        chk({tag, "_last"}, CW'(bus.out_last), '0);
        chk({tag, "_busy"}, CW'(busy), '0);
        chk({tag, "_pe_clear"}, CW'(pe_clear), '0);
        chk({tag, "_overrun"}, CW'(overrun), '0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Known pattern 16*r+c, sink always ready.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) acc_flat[(r*COLS + c)*W +: W] = W'(16*r + c);
        drive(1, 1, 0);
        rand_acc();
        for (int i = 0; i < 6; i++) drive(0, 1, 0);

        // Backpressure while row 1 is presented.
        rand_acc();
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0);

        // done while row 2 is presented, then err_clr once idle.
        rand_acc();
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        rand_acc();
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);

        // Back-to-back tiles: second done lands on the final handshake.
        rand_acc();
        drive(1, 1, 0);
        rand_acc();
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0);

        // Negative element at (0,0), small positive at (0,1).
        rand_acc();
        acc_flat[0 +: W] = 32'hFFFF_FFF6;
        acc_flat[W +: W] = 32'd7;
        drive(1, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0);

        // Reset while row 1 is presented.
        rand_acc();
        drive(1, 1, 0);
        drive(0, 1, 0);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_acc();
            drive(($urandom % 7) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0);
        end

        // Flush and confirm nothing is left owed.
        for (int i = 0; i < ROWS + 3; i++) drive(0, 1, 0);
        chk("queue_empty", CW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
